// File: rtl/bresolve_tx.sv
// Branch-resolution transmitter: classifies resolved branches, packs 42-bit correction packets into a FIFO.
// Enqueue-to-o_valid latency 1 cycle; o_ready drops only when the FIFO is full in RUN, SQUASH always accepts-and-drops.
module bresolve_tx #(
  parameter int unsigned DEPTH      = 4,
  parameter int unsigned INST_BYTES = 4
) (
  input  logic        fire,
  input  logic        rst,
  input  logic        i_valid,
  output logic        o_ready,
  input  logic [31:0] i_pc,
  input  logic [7:0]  i_pos,
  input  logic        i_pred_taken,
  input  logic [31:0] i_pred_target,
  input  logic        i_act_taken,
  input  logic [31:0] i_act_target,
  input  logic        i_flush_done,
  output logic        o_valid,
  input  logic        i_ready,
  output logic [41:0] o_data,
  output logic        o_squashing
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic {
    ST_RUN    = 1'b0,
    ST_SQUASH = 1'b1
  } state_e;

  state_e      state_q;
  logic [41:0] mem_q [DEPTH];
  logic [AW:0] wr_ptr_q;
  logic [AW:0] rd_ptr_q;

  logic        full;
  logic        empty;
  logic        enq;
  logic        deq;
  logic        mispred;
  logic [31:0] corr_pc;
  logic [41:0] pkt;

  // Extra pointer MSB distinguishes a full ring from an empty one.
  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                 (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

  assign o_ready = (state_q == ST_SQUASH) | ~full;
  assign enq     = i_valid & ~full & (state_q == ST_RUN);
  assign deq     = ~empty & i_ready;

  assign mispred = (i_pred_taken != i_act_taken) |
                   (i_act_taken & (i_pred_target != i_act_target));
  assign corr_pc = i_act_taken ? i_act_target : (i_pc + 32'(INST_BYTES));
  assign pkt     = {1'b1, mispred, corr_pc, i_pos};

  always_ff @(posedge fire or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (enq) wr_ptr_q <= wr_ptr_q + (AW+1)'(1);
      if (deq) rd_ptr_q <= rd_ptr_q + (AW+1)'(1);
    end
  end

  // Storage needs no reset: the head is masked whenever the FIFO is empty.
  always_ff @(posedge fire) begin
    if (enq) mem_q[wr_ptr_q[AW-1:0]] <= pkt;
  end

  always_ff @(posedge fire or posedge rst) begin
    if (rst) begin
      state_q <= ST_RUN;
    end else begin
      case (state_q)
        ST_RUN:    if (enq && mispred) state_q <= ST_SQUASH;
        ST_SQUASH: if (i_flush_done)   state_q <= ST_RUN;
        default:   state_q <= ST_RUN;
      endcase
    end
  end

  assign o_squashing = (state_q == ST_SQUASH);
  assign o_valid     = ~empty;
  assign o_data      = empty ? '0 : mem_q[rd_ptr_q[AW-1:0]];

endmodule

// File: tb/tb_bresolve_tx.sv
// Bench for bresolve_tx: constant vector table, directed corner sequences, random run against a queue model.
module tb_bresolve_tx;
  localparam int DEPTH = 4;

  logic        fire = 1'b0;
  logic        rst;
  logic        i_valid;
  logic        o_ready;
  logic [31:0] i_pc;
  logic [7:0]  i_pos;
  logic        i_pred_taken;
  logic [31:0] i_pred_target;
  logic        i_act_taken;
  logic [31:0] i_act_target;
  logic        i_flush_done;
  logic        o_valid;
  logic        i_ready;
  logic [41:0] o_data;
  logic        o_squashing;

  bresolve_tx #(.DEPTH(DEPTH), .INST_BYTES(4)) dut (
    .fire(fire), .rst(rst), .i_valid(i_valid), .o_ready(o_ready),
    .i_pc(i_pc), .i_pos(i_pos), .i_pred_taken(i_pred_taken),
    .i_pred_target(i_pred_target), .i_act_taken(i_act_taken),
    .i_act_target(i_act_target), .i_flush_done(i_flush_done),
    .o_valid(o_valid), .i_ready(i_ready), .o_data(o_data),
    .o_squashing(o_squashing)
  );

  always #5 fire = ~fire;

  typedef struct {
    logic [31:0] pc;
    logic [7:0]  pos;
    logic        pt;
    logic [31:0] ptgt;
    logic        at;
    logic [31:0] atgt;
    logic [41:0] exp_data;
  } vec_t;

  vec_t        vecs [6];
  int          total = 0;
  int          bad   = 0;
  logic [41:0] mq [$];
  bit          msq;
  bit          acc;
  bit          dq;
  logic [41:0] np;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge fire);
    #1;
  endtask

  task automatic idle();
    i_valid = 0; i_pc = '0; i_pos = '0; i_pred_taken = 0; i_pred_target = '0;
    i_act_taken = 0; i_act_target = '0; i_flush_done = 0; i_ready = 0;
  endtask

  task automatic beat(input logic [31:0] pc, input logic [7:0] pos, input logic pt,
                      input logic [31:0] ptgt, input logic at, input logic [31:0] atgt);
    i_valid = 1; i_pc = pc; i_pos = pos; i_pred_taken = pt;
    i_pred_target = ptgt; i_act_taken = at; i_act_target = atgt;
  endtask

  task automatic do_reset();
    idle();
    rst = 1;
    tick();
    tick();
    rst = 0;
  endtask

  // Prediction is right when direction matches and, for a taken branch, the target matches too.
  function automatic logic [41:0] model_pkt(input logic [31:0] pc, input logic [7:0] pos,
      input logic pt, input logic [31:0] ptgt, input logic at, input logic [31:0] atgt);
    logic        right;
    logic [32:0] fall;
    logic [31:0] dest;
    right = (pt == at) && (!at || (ptgt == atgt));
    fall  = {1'b0, pc} + 33'd4;
    dest  = at ? atgt : fall[31:0];
    return {1'b1, !right, dest, pos};
  endfunction

  initial begin
    vecs[0] = '{32'h00001000, 8'h03, 1'b0, 32'h0,      1'b0, 32'h0,      {1'b1, 1'b0, 32'h00001004, 8'h03}};
    vecs[1] = '{32'h00002000, 8'h07, 1'b0, 32'h0,      1'b1, 32'h3000,   {1'b1, 1'b1, 32'h00003000, 8'h07}};
    vecs[2] = '{32'hFFFFFFFC, 8'h09, 1'b1, 32'h10,     1'b1, 32'h20,     {1'b1, 1'b1, 32'h00000020, 8'h09}};
    vecs[3] = '{32'hFFFFFFFC, 8'h0A, 1'b0, 32'h55,     1'b0, 32'h66,     {1'b1, 1'b0, 32'h00000000, 8'h0A}};
    vecs[4] = '{32'h00000400, 8'h20, 1'b1, 32'h500,    1'b1, 32'h500,    {1'b1, 1'b0, 32'h00000500, 8'h20}};
    vecs[5] = '{32'h00000400, 8'h21, 1'b1, 32'h500,    1'b0, 32'h500,    {1'b1, 1'b1, 32'h00000404, 8'h21}};

    rst = 1;
    idle();
    #2;
    chk("reset_o_valid", 64'(o_valid), 64'd0);
    chk("reset_o_data", 64'(o_data), 64'd0);
    chk("reset_o_squashing", 64'(o_squashing), 64'd0);
    chk("reset_o_ready", 64'(o_ready), 64'd1);
    do_reset();

    // Table: one beat each, check the packet, then drain and release any squash.
    for (int v = 0; v < 6; v++) begin
      beat(vecs[v].pc, vecs[v].pos, vecs[v].pt, vecs[v].ptgt, vecs[v].at, vecs[v].atgt);
      tick();
      idle();
      chk($sformatf("vec%0d_o_valid", v), 64'(o_valid), 64'd1);
      chk($sformatf("vec%0d_o_data", v), 64'(o_data), 64'(vecs[v].exp_data));
      chk($sformatf("vec%0d_squash", v), 64'(o_squashing), 64'(vecs[v].exp_data[40]));
      i_ready = 1;
      i_flush_done = 1;
      tick();
      idle();
      chk($sformatf("vec%0d_drained", v), 64'(o_valid), 64'd0);
      chk($sformatf("vec%0d_unsquash", v), 64'(o_squashing), 64'd0);
    end

    // Beats during SQUASH are dropped while o_ready stays high.
    beat(32'h2000, 8'h07, 1'b0, 32'h0, 1'b1, 32'h3000);
    tick();
    for (int k = 0; k < 2; k++) begin
      beat(32'h5000 + 32'(k), 8'h11, 1'b0, 32'h0, 1'b0, 32'h0);
      chk("squash_o_ready", 64'(o_ready), 64'd1);
      tick();
    end
    idle();
    i_ready = 1;
    tick();
    idle();
    chk("squash_dropped", 64'(o_valid), 64'd0);
    chk("squash_still", 64'(o_squashing), 64'd1);
    i_flush_done = 1;
    tick();
    idle();
    chk("flush_to_run", 64'(o_squashing), 64'd0);
    beat(32'h1000, 8'h03, 1'b0, 32'h0, 1'b0, 32'h0);
    tick();
    idle();
    chk("after_flush_enq", 64'(o_data), 64'({1'b1, 1'b0, 32'h00001004, 8'h03}));
    do_reset();

    // Back-pressure: four fill the FIFO, the fifth sees o_ready low.
    for (int k = 0; k < 5; k++) begin
      beat(32'h100 * 32'(k + 1), 8'(k), 1'b0, 32'h0, 1'b0, 32'h0);
      chk($sformatf("bp_o_ready%0d", k), 64'(o_ready), (k < DEPTH) ? 64'd1 : 64'd0);
      tick();
    end
    idle();
    i_ready = 1;
    for (int k = 0; k < DEPTH; k++) begin
      chk($sformatf("bp_drain%0d", k), 64'(o_data),
          64'({1'b1, 1'b0, 32'h100 * 32'(k + 1) + 32'd4, 8'(k)}));
      tick();
    end
    chk("bp_empty", 64'(o_valid), 64'd0);
    idle();

    // Mispredict enqueue with flush_done in the same cycle ends in SQUASH.
    beat(32'h2000, 8'h07, 1'b0, 32'h0, 1'b1, 32'h3000);
    i_flush_done = 1;
    tick();
    idle();
    chk("mispred_vs_flush", 64'(o_squashing), 64'd1);
    i_ready = 1;
    i_flush_done = 1;
    tick();
    idle();

    // Two queued, simultaneous enqueue+dequeue keeps the count at two.
    for (int k = 0; k < 2; k++) begin
      beat(32'hA00 + 32'(k * 16), 8'(k), 1'b0, 32'h0, 1'b0, 32'h0);
      tick();
    end
    beat(32'hA20, 8'h2, 1'b0, 32'h0, 1'b0, 32'h0);
    i_ready = 1;
    tick();
    idle();
    chk("simul_head", 64'(o_data), 64'({1'b1, 1'b0, 32'h00000A14, 8'h01}));
    i_ready = 1;
    tick();
    chk("simul_second", 64'(o_data), 64'({1'b1, 1'b0, 32'h00000A24, 8'h02}));
    tick();
    chk("simul_count2", 64'(o_valid), 64'd0);
    idle();

    // Asynchronous reset with three entries queued in SQUASH.
    beat(32'h10, 8'h1, 1'b0, 32'h0, 1'b0, 32'h0);
    tick();
    beat(32'h20, 8'h2, 1'b0, 32'h0, 1'b0, 32'h0);
    tick();
    beat(32'h30, 8'h3, 1'b1, 32'h40, 1'b0, 32'h0);
    tick();
    idle();
    chk("pre_rst_squash", 64'(o_squashing), 64'd1);
    #2;
    rst = 1;
    #1;
    chk("arst_o_valid", 64'(o_valid), 64'd0);
    chk("arst_o_data", 64'(o_data), 64'd0);
    chk("arst_squash", 64'(o_squashing), 64'd0);
    chk("arst_o_ready", 64'(o_ready), 64'd1);
    tick();
    rst = 0;
    beat(32'h1000, 8'h03, 1'b0, 32'h0, 1'b0, 32'h0);
    tick();
    idle();
    chk("post_rst_enq", 64'(o_data), 64'({1'b1, 1'b0, 32'h00001004, 8'h03}));

    // Random traffic against the queue model.
    do_reset();
    mq.delete();
    msq = 0;
    for (int c = 0; c < 3000; c++) begin
      chk("rnd_o_valid", 64'(o_valid), 64'(mq.size() != 0));
      chk("rnd_o_data", 64'(o_data), (mq.size() != 0) ? 64'(mq[0]) : 64'd0);
      chk("rnd_o_ready", 64'(o_ready), 64'(msq || (mq.size() < DEPTH)));
      chk("rnd_squash", 64'(o_squashing), 64'(msq));
      i_valid       = ($urandom_range(0, 3) != 0);
      i_ready       = ((c / 64) % 2 == 0) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
      i_flush_done  = ($urandom_range(0, 5) == 0);
      i_act_taken   = 1'($urandom_range(0, 1));
      i_pred_taken  = ($urandom_range(0, 7) == 0) ? ~i_act_taken : i_act_taken;
      i_act_target  = $urandom;
      i_pred_target = ($urandom_range(0, 7) == 0) ? $urandom : i_act_target;
      i_pc          = ($urandom_range(0, 15) == 0) ? 32'hFFFFFFFC : $urandom;
      i_pos         = 8'($urandom);
      np  = model_pkt(i_pc, i_pos, i_pred_taken, i_pred_target, i_act_taken, i_act_target);
      acc = i_valid && !msq && (mq.size() < DEPTH);
      dq  = (mq.size() != 0) && i_ready;
      if (dq) void'(mq.pop_front());
      if (acc) mq.push_back(np);
      if (acc && np[40]) msq = 1;
      else if (msq && i_flush_done) msq = 0;
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
